// File: rtl/fill_fifo_ctrl_v2.sv
// rtl/fill_fifo_ctrl_v2.sv - DDR read-address generator feeding the HDMI pixel FIFO
module fill_fifo_ctrl_v2 #(
    parameter int ADDR_W      = 32,
    parameter int CNT_W       = 12,
    parameter int CHUNK_BYTES = 'h100,
    parameter int NUM_BUFS    = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       hsync_I,
    input  logic                       vsync_I,
    input  logic                       fill_half_fifo_I,
    input  logic                       fill_done_I,
    input  logic [NUM_BUFS*ADDR_W-1:0] frame_base_addr_I,
    input  logic [1:0]                 buf_sel_I,
    input  logic [ADDR_W-1:0]          line_stride_I,
    input  logic [ADDR_W-1:0]          line_bytes_I,
    input  logic [CNT_W-1:0]           num_lines_I,
    input  logic [1:0]                 vscale_I,
    output logic [ADDR_W-1:0]          ddr_addr_to_read,
    output logic                       go_fill_fifo,
    output logic                       busy_O,
    output logic                       underrun_O,
    output logic [CNT_W-1:0]           cur_line_O
);
    localparam logic [ADDR_W-1:0] CHUNK = ADDR_W'(CHUNK_BYTES);

    typedef enum logic [2:0] {IDLE, WAIT_VSYNC, READY, REQ, WAIT_DONE} state_t;
    state_t state, state_n;

    logic              hs_q, vs_q, fill_q;
    logic              hs_e, vs_e, fill_e;
    logic [ADDR_W-1:0] line_addr, chunk_off, sel_base;
    logic [CNT_W-1:0]  line_cnt;
    logic [1:0]        rep;
    logic              line_full, fill_pend, hs_pend, vs_pend, underrun;
    logic              done_full, line_adv, last_line;
    logic              do_latch, do_hs, do_done, take_fill, pend_fill, pend_hs, pend_vs, clr_pend;

    assign hs_e   = hsync_I & ~hs_q;
    assign vs_e   = vsync_I & ~vs_q;
    assign fill_e = fill_half_fifo_I & ~fill_q;

    assign done_full = (chunk_off + CHUNK) == line_bytes_I;
    assign line_adv  = (rep == vscale_I);
    assign last_line = line_adv && ((line_cnt + CNT_W'(1)) == num_lines_I);

    // Out-of-range selects fall back to buffer 0
    always_comb begin
        sel_base = frame_base_addr_I[ADDR_W-1:0];
        for (int i = 0; i < NUM_BUFS; i++) begin
            if (buf_sel_I == 2'(i)) sel_base = frame_base_addr_I[i*ADDR_W +: ADDR_W];
        end
    end

    always_comb begin
        state_n   = state;
        do_latch  = 1'b0;
        do_hs     = 1'b0;
        do_done   = 1'b0;
        take_fill = 1'b0;
        pend_fill = 1'b0;
        pend_hs   = 1'b0;
        pend_vs   = 1'b0;
        clr_pend  = 1'b0;
        case (state)
            IDLE: begin
                clr_pend = 1'b1;
                if (start) state_n = WAIT_VSYNC;
            end
            WAIT_VSYNC: begin
                if (!start) state_n = IDLE;
                else if (vs_e) begin
                    do_latch = 1'b1;
                    state_n  = READY;
                end
            end
            READY: begin
                if (!start) state_n = IDLE;
                else if (vs_e) do_latch = 1'b1;
                else if (hs_e) begin
                    do_hs = 1'b1;
                    if (last_line) state_n = WAIT_VSYNC;
                end else if ((fill_e || fill_pend) && !line_full) begin
                    take_fill = 1'b1;
                    state_n   = REQ;
                end
            end
            REQ: begin
                pend_vs   = vs_e;
                pend_hs   = hs_e;
                pend_fill = fill_e && !line_full;
                state_n   = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (fill_done_I) begin
                    do_done   = 1'b1;
                    pend_fill = fill_e && !done_full;
                    state_n   = READY;
                    if (!start) state_n = IDLE;
                    else if (vs_e || vs_pend) do_latch = 1'b1;
                    else if (hs_e || hs_pend) begin
                        do_hs = 1'b1;
                        if (last_line) state_n = WAIT_VSYNC;
                    end
                end else begin
                    pend_vs   = vs_e;
                    pend_hs   = hs_e;
                    pend_fill = fill_e && !line_full;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            fill_q    <= 1'b0;
            line_addr <= '0;
            chunk_off <= '0;
            line_cnt  <= '0;
            rep       <= '0;
            line_full <= 1'b0;
            fill_pend <= 1'b0;
            hs_pend   <= 1'b0;
            vs_pend   <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            state  <= state_n;
            hs_q   <= hsync_I;
            vs_q   <= vsync_I;
            fill_q <= fill_half_fifo_I;
            if (pend_fill) fill_pend <= 1'b1;
            if (take_fill) fill_pend <= 1'b0;
            if (pend_hs)   hs_pend   <= 1'b1;
            if (pend_vs)   vs_pend   <= 1'b1;
            if (do_done) begin
                chunk_off <= chunk_off + CHUNK;
                hs_pend   <= 1'b0;
                vs_pend   <= 1'b0;
                if (done_full) line_full <= 1'b1;
            end
            if (clr_pend) begin
                fill_pend <= 1'b0;
                hs_pend   <= 1'b0;
                vs_pend   <= 1'b0;
            end
            // Line completeness is judged after any chunk retiring this same cycle
            if (do_hs) begin
                if (!(do_done ? done_full : line_full)) underrun <= 1'b1;
                if (line_adv) begin
                    rep       <= '0;
                    line_addr <= line_addr + line_stride_I;
                    line_cnt  <= line_cnt + CNT_W'(1);
                end else begin
                    rep <= rep + 2'd1;
                end
                chunk_off <= '0;
                line_full <= 1'b0;
                fill_pend <= 1'b0;
            end
            if (do_latch) begin
                line_addr <= sel_base;
                chunk_off <= '0;
                line_cnt  <= '0;
                rep       <= '0;
                line_full <= 1'b0;
                fill_pend <= 1'b0;
            end
        end
    end

    assign go_fill_fifo     = (state == REQ);
    assign ddr_addr_to_read = (state == REQ) ? line_addr + chunk_off : '0;
    assign busy_O           = (state == REQ) || (state == WAIT_DONE);
    assign underrun_O       = underrun;
    assign cur_line_O       = line_cnt;
endmodule

// File: tb/tb_fill_fifo_ctrl_v2.sv
// tb/tb_fill_fifo_ctrl_v2.sv - directed vector bench for fill_fifo_ctrl_v2
module tb_fill_fifo_ctrl_v2;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0, hs = 1'b0, vs = 1'b0, fill = 1'b0, done = 1'b0;
    logic [63:0] bases = {32'hA8200000, 32'hA8000000};
    logic [1:0]  buf_sel = 2'd0, vscale = 2'd0;
    logic [31:0] addr;
    logic        go, busy, under;
    logic [11:0] line;
    int          passed = 0, total = 0;

    always #5 clk = ~clk;

    fill_fifo_ctrl_v2 dut (
        .clk(clk), .reset(reset), .start(start), .hsync_I(hs), .vsync_I(vs),
        .fill_half_fifo_I(fill), .fill_done_I(done), .frame_base_addr_I(bases),
        .buf_sel_I(buf_sel), .line_stride_I(32'h500), .line_bytes_I(32'h200),
        .num_lines_I(12'd4), .vscale_I(vscale), .ddr_addr_to_read(addr),
        .go_fill_fifo(go), .busy_O(busy), .underrun_O(under), .cur_line_O(line)
    );

    typedef struct packed {
        logic        start, vs, hs, fill, done;
        logic        go, busy, under;
        logic [31:0] addr;
        logic [11:0] line;
    } vec_t;
    vec_t tbl [16];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (ok) passed++;
        else $display("FAIL %s actual=%h required=%h", nm, act, exp);
    endtask

    task automatic pulse_hs();
        hs = 1'b1; step(); hs = 1'b0; step();
    endtask

    task automatic pulse_vs();
        vs = 1'b1; step(); vs = 1'b0; step();
    endtask

    task automatic wait_go(input logic [31:0] exp, input string nm);
        bit got = 1'b0;
        for (int n = 0; n < 4 && !got; n++) begin
            step();
            fill = 1'b0;
            if (go) begin
                got = 1'b1;
                chk(addr == exp, nm, 64'(addr), 64'(exp));
            end
        end
        if (!got) chk(1'b0, {nm, "_timeout"}, 64'(go), 64'd1);
    endtask

    task automatic fetch(input logic [31:0] exp, input string nm);
        fill = 1'b1;
        wait_go(exp, nm);
        step();
        done = 1'b1; step(); done = 1'b0;
    endtask

    initial begin
        bit quiet;
        tbl[0]  = '{1,0,0,0,0, 0,0,0, 32'h0,        12'd0};
        tbl[1]  = '{1,1,0,0,0, 0,0,0, 32'h0,        12'd0};
        tbl[2]  = '{1,0,0,0,0, 0,0,0, 32'h0,        12'd0};
        tbl[3]  = '{1,0,0,1,0, 1,1,0, 32'hA8000000, 12'd0};
        tbl[4]  = '{1,0,0,0,0, 0,1,0, 32'h0,        12'd0};
        tbl[5]  = '{1,0,0,0,1, 0,0,0, 32'h0,        12'd0};
        tbl[6]  = '{1,0,0,1,0, 1,1,0, 32'hA8000100, 12'd0};
        tbl[7]  = '{1,0,0,0,0, 0,1,0, 32'h0,        12'd0};
        tbl[8]  = '{1,0,0,0,1, 0,0,0, 32'h0,        12'd0};
        tbl[9]  = '{1,0,0,1,0, 0,0,0, 32'h0,        12'd0};
        tbl[10] = '{1,0,0,0,0, 0,0,0, 32'h0,        12'd0};
        tbl[11] = '{1,0,1,0,0, 0,0,0, 32'h0,        12'd1};
        tbl[12] = '{1,0,0,0,0, 0,0,0, 32'h0,        12'd1};
        tbl[13] = '{1,0,0,1,0, 1,1,0, 32'hA8000500, 12'd1};
        tbl[14] = '{1,0,0,0,0, 0,1,0, 32'h0,        12'd1};
        tbl[15] = '{1,0,0,0,1, 0,0,0, 32'h0,        12'd1};

        // Reset held with activity on every input
        quiet = 1'b1;
        for (int i = 0; i < 5; i++) begin
            start = 1'b1; fill = i[0]; hs = ~i[0]; vs = i[1]; done = i[0];
            step();
            if (go || busy || under) quiet = 1'b0;
        end
        chk(quiet, "reset_quiet", {61'd0, go, busy, under}, 64'd0);
        start = 1'b0; fill = 1'b0; hs = 1'b0; vs = 1'b0; done = 1'b0;
        reset = 1'b0;
        step();
        chk(!go && !busy && !under && line == 0 && addr == 0, "reset_state",
            {go, busy, under, line, addr}, 64'd0);

        // Basic walk: two chunks, full-line fill ignored, hsync then next line
        for (int i = 0; i < 16; i++) begin
            start = tbl[i].start; vs = tbl[i].vs; hs = tbl[i].hs;
            fill = tbl[i].fill; done = tbl[i].done;
            step();
            chk(go == tbl[i].go && busy == tbl[i].busy && under == tbl[i].under &&
                line == tbl[i].line && (!tbl[i].go || addr == tbl[i].addr),
                $sformatf("vec%0d", i), {go, busy, under, line, addr},
                {tbl[i].go, tbl[i].busy, tbl[i].under, tbl[i].line, tbl[i].addr});
        end
        done = 1'b0;

        // Vertical repeat: each source line used twice
        vscale = 2'd1;
        pulse_vs();
        fetch(32'hA8000000, "rep_l0a_c0");
        fetch(32'hA8000100, "rep_l0a_c1");
        pulse_hs();
        chk(line == 0, "rep_line_held", 64'(line), 64'd0);
        fetch(32'hA8000000, "rep_l0b_c0");
        fetch(32'hA8000100, "rep_l0b_c1");
        pulse_hs();
        fetch(32'hA8000500, "rep_l1_c0");
        chk(line == 1 && !under, "rep_line1", {line, under}, {12'd1, 1'b0});
        vscale = 2'd0;

        // Buffer select latched only at vsync
        buf_sel = 2'd1;
        pulse_vs();
        fetch(32'hA8200000, "buf1_c0");
        buf_sel = 2'd0;
        fetch(32'hA8200100, "buf1_mid_c1");
        pulse_hs();
        fetch(32'hA8200500, "buf1_mid_l1");
        pulse_vs();
        fetch(32'hA8000000, "buf0_after_vs");

        // Underrun, deferred hsync, end of frame
        pulse_hs();
        chk(under == 1, "underrun_set", 64'(under), 64'd1);
        fetch(32'hA8000500, "after_underrun");
        chk(under == 1, "underrun_sticky", 64'(under), 64'd1);
        fill = 1'b1;
        wait_go(32'hA8000600, "defer_go");
        step();
        hs = 1'b1; step(); hs = 1'b0; step();
        chk(line == 1 && busy, "hs_deferred", {line, busy}, {12'd1, 1'b1});
        done = 1'b1; step(); done = 1'b0;
        chk(line == 2, "hs_applied", 64'(line), 64'd2);
        fetch(32'hA8000A00, "line2_c0");
        pulse_hs();
        pulse_hs();
        begin
            bit seen = 1'b0;
            fill = 1'b1;
            for (int n = 0; n < 4; n++) begin
                step();
                fill = 1'b0;
                if (go) seen = 1'b1;
            end
            chk(!seen, "eof_no_fetch", 64'(seen), 64'd0);
        end
        pulse_vs();
        fetch(32'hA8000000, "after_eof_vs");

        // Reset during WAIT_DONE
        fill = 1'b1; step(); fill = 1'b0; step();
        reset = 1'b1; step();
        chk(!go && !busy && !under && line == 0, "reset_in_wait",
            {go, busy, under, line}, 64'd0);
        reset = 1'b0;
        step();
        pulse_vs();

        // Fill edge during WAIT_DONE is pended and serviced after done
        fill = 1'b1;
        wait_go(32'hA8000000, "pend_first");
        step();
        fill = 1'b1; step(); fill = 1'b0; step();
        chk(busy && !go, "pend_waiting", {busy, go}, {1'b1, 1'b0});
        done = 1'b1; step(); done = 1'b0;
        wait_go(32'hA8000100, "pend_serviced");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
